// File: rtl/cube_move_pkg.sv
// Shared definitions for the cube move engine.
// Provides the turn encodings carried in move_in[FACE_W+1:FACE_W], the
// conventional face indices, the engine state enum and a small helper
// used to size the shared phase timer.
package cube_move_pkg;

  // Turn field encodings
  localparam logic [1:0] TURN_CW      = 2'b00;
  localparam logic [1:0] TURN_CCW     = 2'b01;
  localparam logic [1:0] TURN_HALF    = 2'b10;
  localparam logic [1:0] TURN_ILLEGAL = 2'b11;

  // Face indices (stepper channel numbers)
  localparam int FACE_R = 0;
  localparam int FACE_U = 1;
  localparam int FACE_F = 2;
  localparam int FACE_L = 3;
  localparam int FACE_B = 4;
  localparam int FACE_D = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STEP_HI,
    ST_STEP_LO,
    ST_SETTLE,
    ST_DONE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cube_move_if.sv
// Move handshake bundle between the move source (solver/FIFO) and the engine.
//   move_in    : {turn[1:0], face[FACE_W-1:0]}, source -> engine
//   move_valid : move_in valid, source -> engine
//   move_ready : engine idle and able to accept, engine -> source
//   move_done  : one-cycle pulse when a move is physically complete
//   move_error : one-cycle pulse when an illegal move was rejected
//   busy       : high from accept until move_done
interface cube_move_if #(
  parameter int FACE_W = 3
) ();

  logic [FACE_W+1:0] move_in;
  logic              move_valid;
  logic              move_ready;
  logic              move_done;
  logic              move_error;
  logic              busy;

  modport master (
    output move_in, move_valid,
    input  move_ready, move_done, move_error, busy
  );

  modport slave (
    input  move_in, move_valid,
    output move_ready, move_done, move_error, busy
  );

endinterface

// File: rtl/step_timer.sv
// Loadable down-counter shared by the SETUP, STEP_HI/STEP_LO and SETTLE
// phases. Loading a value N makes tc pulse for one cycle N+1 cycles later
// (i.e. in the last cycle of an (N+1)-cycle phase). A load always wins, so
// the owner can reload in the same cycle it consumes tc.
// Ports: clock, reset (sync, active-high), load, load_val[W-1:0], tc.
module step_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         armed_q, armed_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load) begin
      cnt_d   = load_val;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == '0) armed_d = 1'b0;
      else             cnt_d   = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign tc = armed_q && (cnt_q == '0);

endmodule

// File: rtl/cube_move_engine.sv
// Single-move executor: accepts one encoded face turn per valid/ready
// handshake and drives the step/dir pins of N_FACES stepper channels.
// Ports:
//   clock, reset      : system clock, synchronous active-high reset
//   mv (slave)        : move handshake bundle (see cube_move_if)
//   dir_pin[N_FACES]  : per-channel direction, 0 = CW, 1 = CCW
//   step_pin[N_FACES] : per-channel step pulses
// All outputs are registered; they are computed from the next state so
// they line up with the state they describe.
module cube_move_engine
  import cube_move_pkg::*;
#(
  parameter int N_FACES       = 6,
  parameter int FACE_W        = $clog2(N_FACES),
  parameter int STEPS_QUARTER = 50,
  parameter int STEP_HALF     = 500000,
  parameter int DIR_SETUP     = 100,
  parameter int SETTLE        = 1000000
) (
  input  logic               clock,
  input  logic               reset,
  cube_move_if.slave         mv,
  output logic [N_FACES-1:0] dir_pin,
  output logic [N_FACES-1:0] step_pin
);

  localparam int TW = $clog2(max3(STEP_HALF, DIR_SETUP, SETTLE) + 1);
  localparam int SW = $clog2(2 * STEPS_QUARTER + 1);
  localparam logic [FACE_W:0] FACE_LIMIT = (FACE_W + 1)'(N_FACES);

  state_t              state_q, state_d;
  logic [FACE_W-1:0]   face_q, face_d;
  logic [SW-1:0]       target_q, target_d;
  logic [SW-1:0]       steps_q, steps_d;
  logic [SW-1:0]       steps_inc;
  logic [N_FACES-1:0]  dir_pin_q, dir_pin_d;
  logic [N_FACES-1:0]  step_pin_q, step_pin_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                tmr_load;
  logic [TW-1:0]       tmr_val;
  logic                tmr_tc;

  logic [FACE_W-1:0]   mv_face;
  logic [1:0]          mv_turn;
  logic                accept;
  logic                illegal;
  logic                load_dir;
  logic                new_dir;

  assign mv_face   = mv.move_in[FACE_W-1:0];
  assign mv_turn   = mv.move_in[FACE_W+1:FACE_W];
  assign accept    = mv.move_valid && ready_q;
  assign illegal   = (mv_turn == TURN_ILLEGAL) || ({1'b0, mv_face} >= FACE_LIMIT);
  assign steps_inc = steps_q + SW'(1);

  step_timer #(.W(TW)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Timer is loaded with (duration - 1) on every phase entry so each phase
  // occupies exactly its programmed number of cycles.
  always_comb begin
    state_d  = state_q;
    face_d   = face_q;
    target_d = target_q;
    steps_d  = steps_q;
    error_d  = 1'b0;
    load_dir = 1'b0;
    new_dir  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (illegal) begin
            error_d = 1'b1;
          end else begin
            face_d   = mv_face;
            target_d = (mv_turn == TURN_HALF) ? SW'(2 * STEPS_QUARTER) : SW'(STEPS_QUARTER);
            steps_d  = '0;
            load_dir = 1'b1;
            new_dir  = (mv_turn == TURN_CCW);  // half turns run CW
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = TW'(DIR_SETUP - 1);
          end
        end
      end
      ST_SETUP: begin
        if (tmr_tc) begin
          state_d  = ST_STEP_HI;
          tmr_load = 1'b1;
          tmr_val  = TW'(STEP_HALF - 1);
        end
      end
      ST_STEP_HI: begin
        if (tmr_tc) begin
          state_d  = ST_STEP_LO;
          tmr_load = 1'b1;
          tmr_val  = TW'(STEP_HALF - 1);
        end
      end
      ST_STEP_LO: begin
        if (tmr_tc) begin
          steps_d  = steps_inc;
          tmr_load = 1'b1;
          if (steps_inc == target_q) begin
            state_d = ST_SETTLE;
            tmr_val = TW'(SETTLE - 1);
          end else begin
            state_d = ST_STEP_HI;
            tmr_val = TW'(STEP_HALF - 1);
          end
        end
      end
      ST_SETTLE: begin
        if (tmr_tc) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready_d = (state_d == ST_IDLE);
  assign busy_d  = (state_d != ST_IDLE);
  assign done_d  = (state_d == ST_DONE);

  // Per-channel pin logic: only the latched face's step pin may rise, and
  // a dir pin is rewritten only when its own face is accepted.
  generate
    for (genvar gi = 0; gi < N_FACES; gi++) begin : g_pins
      assign step_pin_d[gi] = (state_d == ST_STEP_HI) && (face_d == FACE_W'(gi));
      assign dir_pin_d[gi]  = (load_dir && (mv_face == FACE_W'(gi))) ? new_dir : dir_pin_q[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      face_q     <= '0;
      target_q   <= '0;
      steps_q    <= '0;
      dir_pin_q  <= '0;
      step_pin_q <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      face_q     <= face_d;
      target_q   <= target_d;
      steps_q    <= steps_d;
      dir_pin_q  <= dir_pin_d;
      step_pin_q <= step_pin_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign mv.move_ready = ready_q;
  assign mv.move_done  = done_q;
  assign mv.move_error = error_q;
  assign mv.busy       = busy_q;
  assign dir_pin       = dir_pin_q;
  assign step_pin      = step_pin_q;

endmodule

// File: tb/tb_cube_move_engine.sv
module tb_cube_move_engine;
  import cube_move_pkg::*;

  localparam int NF = 6;
  localparam int FW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NF-1:0] dir_pin;
  logic [NF-1:0] step_pin;

  int checks = 0;
  int errors = 0;
  logic [NF-1:0] exp_dir_vec = '0;

  cube_move_if #(.FACE_W(FW)) mv_if ();

  cube_move_engine #(
    .N_FACES(NF), .FACE_W(FW), .STEPS_QUARTER(3),
    .STEP_HALF(2), .DIR_SETUP(2), .SETTLE(4)
  ) dut (
    .clock    (clk),
    .reset    (rst),
    .mv       (mv_if),
    .dir_pin  (dir_pin),
    .step_pin (step_pin)
  );

  always #5 clk = ~clk;

  // {step_pin, dir_pin, done, busy, ready, error}
  function automatic logic [2*NF+3:0] obs_vec();
    return {step_pin, dir_pin, mv_if.move_done, mv_if.busy, mv_if.move_ready, mv_if.move_error};
  endfunction

  task automatic note_dir(input logic [FW+1:0] m);
    logic [FW-1:0] f;
    f = m[FW-1:0];
    exp_dir_vec[f] = (m[FW+1:FW] == TURN_CCW);
  endtask

  // Present a legal move and return right after its accept edge.
  task automatic start_move(input string name, input logic [FW+1:0] m);
    @(negedge clk);
    checks++;
    if (mv_if.move_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept got=%b exp=1", name, mv_if.move_ready);
    end
    mv_if.move_in    = m;
    mv_if.move_valid = 1'b1;
    @(posedge clk);
    note_dir(m);
  endtask

  // Cycle-by-cycle check of a move accepted at the previous posedge (k).
  // At cycle k+1 move_in/move_valid are replaced by next_in/hold_valid.
  task automatic check_move(input string name, input int face, input int pulses,
                            input logic [FW+1:0] next_in, input logic hold_valid);
    int lat;
    logic [NF-1:0] es;
    logic [2*NF+3:0] exp_v, got_v;
    lat = 7 + 4 * pulses;
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        mv_if.move_in    = next_in;
        mv_if.move_valid = hold_valid;
      end
      es = '0;
      if (n >= 3 && n < 3 + 4 * pulses && ((n - 3) % 4) < 2) es[face] = 1'b1;
      exp_v = {es, exp_dir_vec, (n == lat), (n <= lat), (n > lat), 1'b0};
      got_v = obs_vec();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s cycle k+%0d got=%b exp=%b", name, n, got_v, exp_v);
      end
    end
    $display("move %s face=%0d pulses=%0d latency=%0d checked", name, face, pulses, lat);
  endtask

  task automatic test_reset();
    logic [2*NF+3:0] exp_v;
    mv_if.move_in    = '0;
    mv_if.move_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    // move presented while reset is high must be ignored
    mv_if.move_in    = {TURN_CW, 3'd0};
    mv_if.move_valid = 1'b1;
    @(negedge clk);
    exp_v = {{NF{1'b0}}, {NF{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_vec() !== exp_v) begin
      errors++;
      $display("FAIL reset_priority got=%b exp=%b", obs_vec(), exp_v);
    end
    mv_if.move_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++;
        $display("FAIL reset_idle cycle=%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
    exp_dir_vec = '0;
    $display("reset: idle outputs checked");
  endtask

  task automatic test_r_cw();
    start_move("R", {TURN_CW, 3'd0});
    check_move("R", FACE_R, 3, '0, 1'b0);
  endtask

  task automatic test_d_half();
    start_move("D2", {TURN_HALF, 3'd5});
    check_move("D2", FACE_D, 6, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    start_move("F'", {TURN_CCW, 3'd2});
    // second move (L CW) held with valid high until accepted at k+20
    check_move("F'", FACE_F, 3, {TURN_CW, 3'd3}, 1'b1);
    @(posedge clk);
    note_dir({TURN_CW, 3'd3});
    check_move("L_b2b", FACE_L, 3, '0, 1'b0);
  endtask

  task automatic test_illegal(input string name, input logic [FW+1:0] m);
    logic [2*NF+3:0] exp_v;
    @(negedge clk);
    mv_if.move_in    = m;
    mv_if.move_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mv_if.move_valid = 1'b0;
    exp_v = {{NF{1'b0}}, exp_dir_vec, 1'b0, 1'b0, 1'b1, 1'b1};
    checks++;
    if (obs_vec() !== exp_v) begin
      errors++;
      $display("FAIL %s error_pulse got=%b exp=%b", name, obs_vec(), exp_v);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_v = {{NF{1'b0}}, exp_dir_vec, 1'b0, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++;
        $display("FAIL %s after_error cycle=%0d got=%b exp=%b", name, i, obs_vec(), exp_v);
      end
    end
    $display("illegal %s move_in=%b checked", name, m);
  endtask

  task automatic test_reset_mid_move();
    logic [2*NF+3:0] exp_v;
    start_move("U_abort", {TURN_CW, 3'd1});
    @(negedge clk);
    mv_if.move_valid = 1'b0;
    repeat (6) @(negedge clk);   // cycle k+7: second STEP_HI
    checks++;
    if (step_pin !== 6'b000010) begin
      errors++;
      $display("FAIL abort_second_hi got=%b exp=%b", step_pin, 6'b000010);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_dir_vec = '0;
    exp_v = {{NF{1'b0}}, {NF{1'b0}}, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs_vec() !== exp_v) begin
      errors++;
      $display("FAIL abort_outputs got=%b exp=%b", obs_vec(), exp_v);
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec() !== exp_v) begin
        errors++;
        $display("FAIL abort_quiet cycle=%0d got=%b exp=%b", i, obs_vec(), exp_v);
      end
    end
    $display("reset mid-move: aborted, no move_done");
    start_move("U'_after", {TURN_CCW, 3'd1});
    check_move("U'_after", FACE_U, 3, '0, 1'b0);
  endtask

  initial begin
    mv_if.move_in    = '0;
    mv_if.move_valid = 1'b0;
    test_reset();
    test_r_cw();
    test_d_half();
    test_back_to_back();
    test_illegal("turn11", {TURN_ILLEGAL, 3'd1});
    test_illegal("face6", {TURN_CW, 3'd6});
    test_reset_mid_move();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
